// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan driver: scan FSM states,
// the hex-to-segment table and the all-segments-off cathode pattern.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

  // Active-low cathode pattern with every segment dark.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-high {G,F,E,D,C,B,A} patterns, entry 15 first.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    return SEG_TABLE[hex];
  endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Slot timer for the scan driver: counts cycles within a digit slot and
// steps the digit index at each slot end. Exposes the next-cycle counter
// position as flags so the driver can register outputs aligned with state.
module seg7_scan_timer #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             run_i,
  output logic             blank_done_o,
  output logic             slot_done_o,
  output logic [IDX_W-1:0] idx_next_o,
  output logic             frame_start_next_o,
  output logic             frame_last_next_o
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Next slot position: clear to digit 0, or advance and wrap at slot end.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (clear_i) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (run_i) begin
      if (cnt_q == CNT_SLOT_LAST) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Slot counter and digit index registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign blank_done_o       = (cnt_q == CNT_BLANK_LAST);
  assign slot_done_o        = (cnt_q == CNT_SLOT_LAST);
  assign idx_next_o         = idx_d;
  assign frame_start_next_o = (cnt_d == '0) && (idx_d == '0);
  assign frame_last_next_o  = (cnt_d == CNT_SLOT_LAST) && (idx_d == IDX_LAST);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with a double-buffered
// value register committed at frame boundaries (or at once while idle).
// Build option SEG7_LZB_EN enables leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  output logic                    pending_o,
  output logic                    frame_done_o,
  output logic [NUM_DIGITS-1:0]   anode_no,
  output logic [6:0]              seg_no,
  output logic                    dp_no
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  scan_state_e state_q, state_d;

  logic             blank_done, slot_done, frame_start_next, frame_last_next;
  logic [IDX_W-1:0] idx_next;

  logic [4*NUM_DIGITS-1:0] shadow_val_q, active_val_q;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, active_dp_q;
  logic                    pending_q;
  logic                    commit;

  logic [3:0] digit_sel;
  logic       dp_sel;
  logic       lzb_blank;

  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_done_q, frame_done_d;

  seg7_scan_timer #(
    .NUM_DIGITS   (NUM_DIGITS),
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .IDX_W        (IDX_W)
  ) u_timer (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .clear_i            (state_d == IDLE),
    .run_i              (state_q != IDLE),
    .blank_done_o       (blank_done),
    .slot_done_o        (slot_done),
    .idx_next_o         (idx_next),
    .frame_start_next_o (frame_start_next),
    .frame_last_next_o  (frame_last_next)
  );

  // Scan FSM next state; dropping enable idles from any state.
  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = BLANK;
        BLANK:   if (blank_done) state_d = SHOW;
        SHOW:    if (slot_done)  state_d = BLANK;
        default: state_d = IDLE;
      endcase
    end
  end

  // Scan FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= BLANK;
    else       state_q <= state_d;
  end

  // Shadow moves to active on entry to digit 0's BLANK, or whenever idle.
  assign commit = pending_q &&
                  ((state_q == IDLE) || ((state_d == BLANK) && frame_start_next));

  // Select the digit and dp bit of the slot being entered.
  always_comb begin
    digit_sel = 4'h0;
    dp_sel    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_next == IDX_W'(i)) begin
        digit_sel = active_val_q[4*i +: 4];
        dp_sel    = active_dp_q[i];
      end
    end
  end

`ifdef SEG7_LZB_EN
  logic lzb_run;

  // Blank a non-zero-index digit without dp when it and all digits above are 0.
  always_comb begin
    lzb_run   = 1'b1;
    lzb_blank = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lzb_run = lzb_run && (active_val_q[4*i +: 4] == 4'h0);
      if ((idx_next == IDX_W'(i)) && (i != 0) && !active_dp_q[i] && lzb_run)
        lzb_blank = 1'b1;
    end
  end
`else
  assign lzb_blank = 1'b0;
`endif

  // Pin values for the next cycle, computed from the next state so that the
  // registered pins line up with the FSM state they belong to.
  always_comb begin
    anode_d      = '1;
    seg_d        = SEG_OFF;
    dp_d         = 1'b1;
    frame_done_d = 1'b0;
    if (state_d == SHOW) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_next == IDX_W'(i)) anode_d[i] = 1'b0;
      end
      seg_d        = lzb_blank ? SEG_OFF : ~hex_to_seg(digit_sel);
      dp_d         = ~dp_sel;
      frame_done_d = frame_last_next;
    end
  end

  // Load/commit buffers and registered display pins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      active_val_q <= '0;
      active_dp_q  <= '0;
      pending_q    <= 1'b0;
      anode_q      <= '1;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      if (load_i) begin
        shadow_val_q <= value_i;
        shadow_dp_q  <= dp_i;
      end
      if (commit) begin
        active_val_q <= shadow_val_q;
        active_dp_q  <= shadow_dp_q;
      end
      pending_q    <= load_i || (pending_q && !commit);
      anode_q      <= anode_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pending_o    = pending_q;
  assign frame_done_o = frame_done_q;
  assign anode_no     = anode_q;
  assign seg_no       = seg_q;
  assign dp_no        = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (4 digits, 8-cycle slots, 2 blank).
// Expected digit slots are queued when a value is driven and compared as
// each SHOW slot begins. Inputs change and outputs are sampled on negedge.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic        pending, frame_done, dpo;
  logic [3:0]  anode;
  logic [6:0]  seg;

  int n_cmp = 0;
  int n_err = 0;
  int c = 0;

  typedef struct {
    string      tag;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb[$];

  seg7_scan_driver #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (enable),
    .load_i       (load),
    .value_i      (value),
    .dp_i         (dp),
    .pending_o    (pending),
    .frame_done_o (frame_done),
    .anode_no     (anode),
    .seg_no       (seg),
    .dp_no        (dpo)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_pat(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input logic [3:0] d, input int i);
    logic blank;
    blank = 1'b0;
`ifdef SEG7_LZB_EN
    if (i != 0 && !d[i]) begin
      blank = 1'b1;
      for (int j = i; j < 4; j++) if (v[j*4 +: 4] != 4'h0) blank = 1'b0;
    end
`endif
    return blank ? 7'h7F : ~seg_pat(v[i*4 +: 4]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, c);
    end
  endtask

  task automatic step();
    @(negedge clk);
    c++;
  endtask

  task automatic step_to(input int target);
    while (c < target) step();
  endtask

  task automatic push_digit(input string tag, input logic [15:0] v, input logic [3:0] d, input int i);
    exp_t e;
    e.tag = $sformatf("%s_d%0d", tag, i);
    e.an  = ~(4'b0001 << i);
    e.seg = exp_seg(v, d, i);
    e.dp  = ~d[i];
    sb.push_back(e);
  endtask

  task automatic push_frame(input string tag, input logic [15:0] v, input logic [3:0] d);
    for (int i = 0; i < 4; i++) push_digit(tag, v, d, i);
  endtask

  // Advance to the start of the next SHOW slot, bounded.
  task automatic wait_show_start(output bit ok);
    int n;
    n = 0;
    while (anode !== 4'hF && n < 64) begin step(); n++; end
    while (anode === 4'hF && n < 64) begin step(); n++; end
    ok = (n < 64);
  endtask

  task automatic pop_check();
    exp_t e;
    bit   ok;
    wait_show_start(ok);
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL sb_empty: observed 0 entries expected 1 (cycle %0d)", c);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_timeout"}, ok, 1);
      check({e.tag, "_an"}, anode, e.an);
      check({e.tag, "_seg"}, seg, e.seg);
      check({e.tag, "_dp"}, dpo, e.dp);
    end
  endtask

  task automatic wait_frame_done();
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < 40) begin step(); n++; end
  endtask

  initial begin
    int bad, good;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_an", anode, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dpo, 1'b1);
    check("rst_pend", pending, 1'b0);
    check("rst_fd", frame_done, 1'b0);

    // Test 1: release with enable, display 0000
    rst = 1'b0; enable = 1'b1; c = 0;
    step();
    check("t1_blank", anode, 4'hF);
    step();
    check("t1_show_an", anode, 4'hE);
    check("t1_show_seg", seg, 7'h40);
    check("t1_show_dp", dpo, 1'b1);
    step_to(7);
    check("t1_show_last", anode, 4'hE);
    step();
    check("t1_blank_d1", anode, 4'hF);
    wait_frame_done();
    check("t1_fd_first", c, 31);
    step();
    wait_frame_done();
    check("t1_fd_period", c, 63);
    step();
    check("t1_fd_pulse", frame_done, 1'b0);

    // Test 2: mid-frame load commits at next boundary
    step_to(70);
    value = 16'h12AF; dp = 4'h0; load = 1'b1;
    step();
    load = 1'b0;
    check("t2_pend_set", pending, 1'b1);
    step_to(95);
    check("t2_pend_hold", pending, 1'b1);
    step();
    check("t2_pend_clr", pending, 1'b0);
    push_frame("t2", 16'h12AF, 4'h0);
    repeat (4) pop_check();

    // Test 3: last load in a frame wins
    step_to(123);
    value = 16'h1111; load = 1'b1;
    step();
    value = 16'h2222;
    step();
    load = 1'b0;
    check("t3_pend", pending, 1'b1);
    step_to(127);
    bad = 0; good = 0;
    repeat (32) begin
      step();
      if (anode !== 4'hF && seg === 7'h79) bad++;
      if (anode !== 4'hF && seg === 7'h24) good++;
    end
    check("t3_no_1111", bad, 0);
    check("t3_2222_cycles", good, 24);

    // Test 4: disable mid-SHOW, idle commit, re-enable
    step_to(165);
    check("t4_pre_an", anode, 4'hE);
    enable = 1'b0;
    step();
    check("t4_idle_an", anode, 4'hF);
    check("t4_idle_seg", seg, 7'h7F);
    check("t4_idle_dp", dpo, 1'b1);
    step_to(168);
    value = 16'h0009; load = 1'b1;
    step();
    load = 1'b0;
    check("t4_pend_set", pending, 1'b1);
    step();
    check("t4_pend_clr", pending, 1'b0);
    step_to(172);
    enable = 1'b1;
    push_digit("t4", 16'h0009, 4'h0, 0);
    push_digit("t4", 16'h0009, 4'h0, 1);
    pop_check();
    check("t4_restart_cyc", c, 175);
    pop_check();

    // Test 5: reset mid-SHOW of digit 2 with a pending load
    step_to(192);
    value = 16'hABCD; load = 1'b1;
    step();
    load = 1'b0;
    check("t5_pend_set", pending, 1'b1);
    check("t5_digit2_an", anode, 4'hB);
    rst = 1'b1;
    step();
    check("t5_rst_an", anode, 4'hF);
    check("t5_rst_seg", seg, 7'h7F);
    check("t5_rst_dp", dpo, 1'b1);
    check("t5_rst_pend", pending, 1'b0);
    check("t5_rst_fd", frame_done, 1'b0);
    rst = 1'b0;
    push_frame("t5", 16'h0000, 4'h0);
    repeat (4) pop_check();

    // Test 6: value with leading zeros
    step_to(221);
    value = 16'h0050; dp = 4'h0; load = 1'b1;
    step();
    load = 1'b0;
    step_to(225);
    check("t6_pend_hold", pending, 1'b1);
    step();
    check("t6_pend_clr", pending, 1'b0);
    push_frame("t6", 16'h0050, 4'h0);
    repeat (4) pop_check();

    // Test 7: decimal point on digit 2 of an all-zero value
    step_to(253);
    value = 16'h0000; dp = 4'b0100; load = 1'b1;
    step();
    load = 1'b0;
    step_to(257);
    check("t7_pend_hold", pending, 1'b1);
    step();
    check("t7_pend_clr", pending, 1'b0);
    push_frame("t7", 16'h0000, 4'b0100);
    repeat (4) pop_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for a common-anode multi-digit 7-segment display.
- Owns the display side of the hex-digit-to-segment interface: accepts a packed multi-digit hex value, then scans one digit per slot with shared active-low cathodes and per-digit active-low anodes.
- Sits between game score/status logic and the board display pins.
- Value updates are double-buffered and committed only at frame boundaries, so the display never tears.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- REFRESH_DIV, 100000, clock cycles per digit slot (BLANK plus SHOW).
- BLANK_CYCLES, 1000, cycles per slot with all anodes off (ghosting guard); must be 1 ≤ BLANK_CYCLES < REFRESH_DIV.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- enable_i  in  1  scan enable; low blanks the display
- load_i  in  1  load strobe for value_i/dp_i
- value_i  in  4*NUM_DIGITS  hex digits; digit 0 = bits [3:0], rightmost
- dp_i  in  NUM_DIGITS  decimal-point request per digit, active-high
- pending_o  out  1  a loaded value awaits commit
- frame_done_o  out  1  one-cycle pulse at the end of the last digit's SHOW
- anode_no  out  NUM_DIGITS  digit enables, active-low
- seg_no  out  7  cathodes {G,F,E,D,C,B,A}, active-low
- dp_no  out  1  decimal-point cathode, active-low

Behaviour:
- One clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: anode_no all 1s; seg_no 7'h7F; dp_no 1; pending_o 0; frame_done_o 0.
- Reset also clears the shadow and active registers to 0, sets digit index to 0, state BLANK, slot counter 0.
- Reset mid-scan aborts the slot immediately; a pending load is discarded.
- FSM states:
  - IDLE: anodes off.
  - BLANK: anodes off, segments off; lasts BLANK_CYCLES cycles.
  - SHOW: anode[idx] = 0, segments driven; lasts REFRESH_DIV − BLANK_CYCLES cycles.
- FSM transitions:
  - BLANK → SHOW → BLANK with idx+1.
  - From idx = NUM_DIGITS−1, idx wraps to 0. frame_done_o pulses on the last SHOW cycle of that digit.
  - Frame length is NUM_DIGITS*REFRESH_DIV cycles.
  - enable_i = 0 in any state → IDLE next cycle.
  - IDLE with enable_i = 1 → BLANK, idx 0, counter 0.
- Load handshake:
  - load_i = 1 captures value_i/dp_i into the shadow register and sets pending_o the next cycle.
  - Repeated loads before commit overwrite the shadow; last load wins.
- Commit:
  - Shadow → active at the frame boundary (the cycle the FSM enters BLANK with idx 0), or on any cycle in IDLE.
  - pending_o clears on the cycle the commit takes effect.
  - A load on the commit cycle itself is captured and stays pending for the next boundary.
- Segment encoding (active-high, {G..A}), inverted onto seg_no:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- dp_no = ~active_dp[idx] during SHOW, 1 otherwise.
- The SHOW outputs for a slot reflect the active register at that slot's start.

Optional Feature:
- Macro: SEG7_LZB_EN (leading-zero blanking).
- Defined: during SHOW, a digit whose value and all more-significant digits are 0 keeps its anode asserted but drives seg_no 7'h7F.
  - Exceptions: digit 0 is never blanked, and a digit with its dp bit set is never blanked.
- Undefined: every digit is displayed; no extra logic.

Decomposition:
- Package seg7_pkg holds:
  - typedef scan_state_e {IDLE, BLANK, SHOW};
  - the 16-entry segment constant table;
  - function hex_to_seg(4-bit) returning the active-high {G..A} pattern;
  - localparam SEG_OFF = 7'h7F.
- Sub-module seg7_scan_timer: slot counter plus BLANK/SHOW phase and wrap/last-digit flags, parameterised by REFRESH_DIV and BLANK_CYCLES.

Test Plan:
- All tests use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
1. Reset release, enable_i=1, no load -> anodes 1111 for 2 cycles; then anode_no=1110 with seg_no=7'h40 ("0") for 6 cycles; frame_done_o pulses every 32 cycles.
2. load_i with value_i=16'h12AF mid-frame -> pending_o=1 until the next boundary; next frame shows:
   - digit0 seg_no=7'h0E (F)
   - digit1 seg_no=7'h08 (A)
   - digit2 seg_no=7'h24 (2)
   - digit3 seg_no=7'h79 (1)
3. Loads of 16'h1111 then 16'h2222 in the same frame -> only 2222 is displayed; the 1111 pattern never appears on seg_no.
4. enable_i=0 mid-SHOW -> anode_no=1111 next cycle; load 16'h0009 while idle commits on the following cycle (pending_o 1 for one cycle). Re-enable -> scan restarts at digit 0 after 2 BLANK cycles.
5. rst_i asserted mid-SHOW of digit 2 with a pending load -> next cycle all outputs at reset values, pending_o=0; the display then shows 0000.
6. SEG7_LZB_EN defined, value 16'h0050, dp_i=0 ->
   - digits 3 and 2: seg_no=7'h7F with anode asserted
   - digit1 = 7'h12 ("5")
   - digit0 = 7'h40 ("0")
